// File: rtl/instruction_encoder_pkg.sv
// Shared constants for the RV32 instruction encoder: format codes,
// major-opcode classes (opcode[6:2]) and the NOP word used for rejects.
package instruction_encoder_pkg;

  localparam logic [2:0] R_TYPE = 3'd0;
  localparam logic [2:0] I_TYPE = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] B_TYPE = 3'd3;
  localparam logic [2:0] U_TYPE = 3'd4;
  localparam logic [2:0] J_TYPE = 3'd5;

  localparam logic [4:0] OPC_LOAD       = 5'b00000;
  localparam logic [4:0] OPC_LOAD_FP    = 5'b00001;
  localparam logic [4:0] OPC_OP_IMM     = 5'b00100;
  localparam logic [4:0] OPC_OP_IMM_32  = 5'b00110;
  localparam logic [4:0] OPC_JALR       = 5'b11001;
  localparam logic [4:0] OPC_BRANCH     = 5'b11000;
  localparam logic [4:0] OPC_OP         = 5'b01100;
  localparam logic [4:0] OPC_OP_FP      = 5'b10100;
  localparam logic [4:0] OPC_STORE      = 5'b01000;
  localparam logic [4:0] OPC_STORE_FP   = 5'b01001;
  localparam logic [4:0] OPC_AUIPC      = 5'b00101;
  localparam logic [4:0] OPC_LUI        = 5'b01101;
  localparam logic [4:0] OPC_JAL        = 5'b11011;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  // True when the opcode class is one the given format can legally carry.
  function automatic logic class_matches(input logic [2:0] fmt, input logic [4:0] cls);
    logic ok;
    ok = 1'b0;
    unique case (fmt)
      R_TYPE: ok = (cls == OPC_OP) || (cls == OPC_OP_FP);
      I_TYPE: ok = (cls == OPC_LOAD) || (cls == OPC_LOAD_FP) || (cls == OPC_OP_IMM) ||
                   (cls == OPC_OP_IMM_32) || (cls == OPC_JALR);
      S_TYPE: ok = (cls == OPC_STORE) || (cls == OPC_STORE_FP);
      B_TYPE: ok = (cls == OPC_BRANCH);
      U_TYPE: ok = (cls == OPC_AUIPC) || (cls == OPC_LUI);
      J_TYPE: ok = (cls == OPC_JAL);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-bundle input and encoded-word output of the instruction encoder.
interface instruction_encoder_if #(
  parameter int FIFO_DEPTH = 2
);
  import instruction_encoder_pkg::*;

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        instruction_type;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        read_index_1;
  logic [4:0]        read_index_2;
  logic [4:0]        write_index;
  logic [31:0]       immediate;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instruction;
  logic              illegal;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output in_valid, instruction_type, opcode, funct3, funct7,
           read_index_1, read_index_2, write_index, immediate, out_ready,
    input  in_ready, out_valid, instruction, illegal, occupancy
  );

  modport slave (
    input  in_valid, instruction_type, opcode, funct3, funct7,
           read_index_1, read_index_2, write_index, immediate, out_ready,
    output in_ready, out_valid, instruction, illegal, occupancy
  );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// Synchronous FIFO holding encoded words ({illegal, instruction}).
// Pointers wrap naturally because DEPTH is a power of two.
module instruction_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count < DEPTH_C);
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset drops every buffered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs a decoded field bundle into an RV32 instruction word, flags bundles
// that cannot be encoded (emitted as NOP), and buffers results in a FIFO.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_encoder_if.slave  bus
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  logic [31:0]      imm;
  logic [31:0]      packed_word;
  logic             bad_bundle;
  logic [32:0]      entry;
  logic [32:0]      head;
  logic [OCC_W-1:0] occ;
  logic             accept;
  logic             take;

  assign imm = bus.immediate;

  // Field packing per format; unused immediate bits simply drop out.
  always_comb begin
    packed_word = NOP_WORD;
    unique case (bus.instruction_type)
      R_TYPE: packed_word = {bus.funct7, bus.read_index_2, bus.read_index_1,
                             bus.funct3, bus.write_index, bus.opcode};
      I_TYPE: packed_word = {imm[11:0], bus.read_index_1, bus.funct3,
                             bus.write_index, bus.opcode};
      S_TYPE: packed_word = {imm[11:5], bus.read_index_2, bus.read_index_1,
                             bus.funct3, imm[4:0], bus.opcode};
      B_TYPE: packed_word = {imm[12], imm[10:5], bus.read_index_2, bus.read_index_1,
                             bus.funct3, imm[4:1], imm[11], bus.opcode};
      U_TYPE: packed_word = {imm[31:12], bus.write_index, bus.opcode};
      J_TYPE: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                             bus.write_index, bus.opcode};
      default: packed_word = NOP_WORD;
    endcase
  end

  // Legality: compressed-space opcodes, unknown formats, format/class
  // mismatch, and odd branch/jump offsets all make the bundle unencodable.
  always_comb begin
    bad_bundle = 1'b0;
    if (bus.opcode[1:0] != 2'b11) bad_bundle = 1'b1;
    if (bus.instruction_type > J_TYPE) bad_bundle = 1'b1;
    if (!class_matches(bus.instruction_type, bus.opcode[6:2])) bad_bundle = 1'b1;
    if (((bus.instruction_type == B_TYPE) || (bus.instruction_type == J_TYPE)) && imm[0])
      bad_bundle = 1'b1;
  end

  assign entry = bad_bundle ? {1'b1, NOP_WORD} : {1'b0, packed_word};

  // in_ready looks only at occupancy (and reset), never at out_ready.
  assign bus.in_ready = !reset && (occ < DEPTH_C);
  assign accept       = bus.in_valid && bus.in_ready;
  assign take         = bus.out_valid && bus.out_ready;

  instruction_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (entry),
    .pop       (take),
    .pop_data  (head),
    .count     (occ)
  );

  assign bus.out_valid   = (occ != '0);
  assign bus.instruction = bus.out_valid ? head[31:0] : 32'h0;
  assign bus.illegal     = bus.out_valid && head[32];
  assign bus.occupancy   = occ;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: format packing, illegal bundles,
// back-pressure ordering and reset while words are buffered.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  instruction_encoder_if #(.FIFO_DEPTH(2)) bus ();

  instruction_encoder #(.FIFO_DEPTH(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm);
    bus.instruction_type = t;
    bus.opcode           = op;
    bus.funct3           = f3;
    bus.funct7           = f7;
    bus.read_index_1     = rs1;
    bus.read_index_2     = rs2;
    bus.write_index      = rd;
    bus.immediate        = imm;
  endtask

  // One bundle through an idle encoder with the consumer always ready.
  task automatic single(input string tag, input logic [2:0] t, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                        input logic [31:0] exp_word, input logic exp_ill);
    int n;
    drive(t, op, f3, f7, rs1, rs2, rd, imm);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " word"}, bus.instruction, exp_word);
    chk({tag, " illegal"}, 32'(bus.illegal), 32'(exp_ill));
    tick();
    chk({tag, " drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    tick();
    tick();
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst instruction", bus.instruction, 32'd0);
    chk("rst illegal", 32'(bus.illegal), 32'd0);
    reset = 1'b0;
    tick();
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    single("addi", I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h00500093, 1'b0);
    single("add",  R_TYPE, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
    single("sw",   S_TYPE, 7'b0100011, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h0020A423, 1'b0);
    single("lui",  U_TYPE, 7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h123452B7, 1'b0);
    single("beq",  B_TYPE, 7'b1100011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    single("jal",  J_TYPE, 7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h00000800, 32'h001000EF, 1'b0);
    single("b odd", B_TYPE, 7'b1100011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3, NOP_WORD, 1'b1);
    single("r mism", R_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, NOP_WORD, 1'b1);
    single("op 0x10", I_TYPE, 7'h10, 3'd0, 7'd0, 5'd1, 5'd0, 5'd1, 32'd5, NOP_WORD, 1'b1);
    single("type 6", 3'd6, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, NOP_WORD, 1'b1);
    single("j odd", J_TYPE, 7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h00000801, NOP_WORD, 1'b1);

    // Back-pressure: A and B fill the buffer, C waits until A drains.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(R_TYPE, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    drive(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    tick();
    drive(S_TYPE, 7'b0100011, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    chk("bp full in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp full occ", 32'(bus.occupancy), 32'd2);
    chk("bp head A", bus.instruction, 32'h002081B3);
    tick();
    chk("bp hold occ", 32'(bus.occupancy), 32'd2);
    chk("bp hold A", bus.instruction, 32'h002081B3);
    chk("bp hold in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp pop A occ", 32'(bus.occupancy), 32'd1);
    chk("bp head B", bus.instruction, 32'h00500093);
    chk("bp in_ready back", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp push+pop occ", 32'(bus.occupancy), 32'd1);
    chk("bp head C", bus.instruction, 32'h0020A423);
    tick();
    chk("bp empty occ", 32'(bus.occupancy), 32'd0);
    chk("bp empty valid", 32'(bus.out_valid), 32'd0);

    // Reset with two words buffered; a later bundle must come out alone.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(R_TYPE, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    drive(I_TYPE, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    tick();
    bus.in_valid = 1'b0;
    chk("rt pre occ", 32'(bus.occupancy), 32'd2);
    reset = 1'b1;
    tick();
    chk("rt out_valid", 32'(bus.out_valid), 32'd0);
    chk("rt occ", 32'(bus.occupancy), 32'd0);
    chk("rt instruction", bus.instruction, 32'd0);
    chk("rt in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    drive(U_TYPE, 7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("rt new occ", 32'(bus.occupancy), 32'd1);
    chk("rt new word", bus.instruction, 32'h123452B7);
    bus.out_ready = 1'b1;
    tick();
    chk("rt alone valid", 32'(bus.out_valid), 32'd0);
    chk("rt alone occ", 32'(bus.occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, output buffer entries; power of two, >=2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  field bundle valid.
REQ-005 in_ready  output  1  encoder can accept a bundle.
REQ-006 instruction_type  input  3  R=0, I=1, S=2, B=3, U=4, J=5.
REQ-007 opcode  input  7  major opcode.
REQ-008 funct3  input  3  / funct7  input  7  function fields.
REQ-009 read_index_1, read_index_2, write_index  input  5 each  rs1, rs2, rd.
REQ-010 immediate  input  32  sign-extended immediate value, unencoded.
REQ-011 out_valid  output  1  encoded word available.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 instruction  output  32  encoded RV32 instruction word.
REQ-014 illegal  output  1  sideband, qualified by out_valid: the bundle was not encodable.
REQ-015 occupancy  output  $clog2(FIFO_DEPTH)+1  entries held.

Function
REQ-016 A bundle SHALL be accepted on a cycle with in_valid && in_ready.
REQ-017 A bundle SHALL be encoded combinationally and pushed into the FIFO on acceptance; out_valid SHALL rise the next cycle (latency 1).
REQ-018 in_ready SHALL equal (occupancy < FIFO_DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-019 A word SHALL pop on out_valid && out_ready; instruction/illegal SHALL be stable while out_valid && !out_ready.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; order SHALL be FIFO.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 R: funct7|rs2|rs1|funct3|rd|opcode.
REQ-023 I: imm[11:0]|rs1|funct3|rd|opcode.
REQ-024 S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-025 B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-026 U: imm[31:12]|rd|opcode.
REQ-027 J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-028 A bundle SHALL be illegal when any of the following holds: opcode[1:0] != 2'b11; type > 5; type inconsistent with opcode[6:2] (I: 00000/00001/00100/00110/11001; B: 11000; R: 01100/10100; S: 01000/01001; U: 00101/01101; J: 11011); imm[0]=1 for B/J.
REQ-029 An illegal bundle SHALL still be accepted and emitted as 32'h00000013 (NOP) with illegal=1.
REQ-030 Unused immediate bits SHALL be ignored, with no range check.

Reset
REQ-031 While reset is high: occupancy=0, out_valid=0, illegal=0, instruction=0, pointers=0.
REQ-032 in_ready SHALL be 0 while reset is high and 1 on the first cycle after release.
REQ-033 A reset during traffic SHALL discard all buffered words; no partial word SHALL appear afterwards.

Structure
REQ-034 The shared package SHALL hold the type codes R_TYPE..J_TYPE, the opcode[6:2] class constants and NOP_WORD=32'h00000013; the decoder SHALL use the same package.
REQ-035 Storage SHALL be one sub-module, instruction_fifo (synchronous FIFO, width 33, depth FIFO_DEPTH); the encoding logic SHALL stay in instruction_encoder.

Verification
REQ-036 Scenario: I, op 0010011, f3 0, rd 1, rs1 0, imm 5 -> 0x00500093, illegal=0, one cycle after acceptance.
REQ-037 Scenario: R add x3,x1,x2 -> 0x002081B3; S sw x2,8(x1) -> 0x0020A423; U lui x5, imm 0x12345000 -> 0x123452B7.
REQ-038 Scenario: B beq x1,x2, imm -4 -> 0xFE208EE3; J jal x1, imm 0x800 -> 0x001000EF; B with imm 3 -> 0x00000013, illegal=1.
REQ-039 Scenario: type R with opcode 0010011 -> 0x00000013, illegal=1; opcode 0x10 -> illegal=1.
REQ-040 Scenario: out_ready=0 with 3 valid bundles -> 2 accepted, in_ready=0, occupancy=2; raise out_ready -> words in order, then third accepted; push+pop at full holds occupancy.
REQ-041 Scenario: reset asserted at occupancy 2 -> next cycle out_valid=0, occupancy=0; a new bundle then emerges alone.
